// File: rtl/frame_reorder.sv
// Ping-pong frame buffer: fills one bank while draining the other, emitting
// each frame either in arrival order or time-reversed.
//
// bank state | meaning
// EMPTY      | bank may be written; wr_cnt indexes the next free slot
// FULL       | complete frame held with its latched length and mode; awaiting drain
module frame_reorder #(
   parameter int BITS  = 8,
   parameter int MAX_N = 16,
   parameter int LW    = $clog2(MAX_N + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [LW-1:0]   frame_len,
   input  logic            mode,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [BITS-1:0] in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [BITS-1:0] out_data,
   output logic            out_last
);

   localparam int AW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
   localparam logic [LW-1:0] ONE   = LW'(1);
   localparam logic [LW-1:0] LEN_MAX = LW'(MAX_N);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_st_t;

   bank_st_t        bank_st   [2];
   logic [LW-1:0]   bank_len  [2];
   logic            bank_mode [2];
   logic [BITS-1:0] mem       [2][MAX_N];

   logic            wr_bank;
   logic            rd_bank;
   logic [LW-1:0]   wr_cnt;
   logic [LW-1:0]   rd_cnt;

   logic [LW-1:0]   eff_len;
   logic [LW-1:0]   cur_len;
   logic [LW-1:0]   rd_len;
   logic [LW-1:0]   rd_addr;
   logic            accept;
   logic            wr_last;
   logic            rd_last;
   logic            load;

   assign in_ready = (bank_st[wr_bank] == EMPTY);
   assign eff_len  = ((frame_len == '0) || (frame_len > LEN_MAX)) ? LEN_MAX : frame_len;

   // The first sample of a frame completes against the live length, since
   // the bank's latched length is only being written in that same cycle.
   assign cur_len  = (wr_cnt == '0) ? eff_len : bank_len[wr_bank];
   assign accept   = in_valid & in_ready & ~flush;
   assign wr_last  = (wr_cnt == cur_len - ONE);

   assign rd_len   = bank_len[rd_bank];
   assign rd_last  = (rd_cnt == rd_len - ONE);
   assign rd_addr  = bank_mode[rd_bank] ? (rd_len - ONE - rd_cnt) : rd_cnt;
   assign load     = (bank_st[rd_bank] == FULL) & (~out_valid | out_ready);

   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_bank][wr_cnt[AW-1:0]] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            bank_st[i]   <= EMPTY;
            bank_len[i]  <= LEN_MAX;
            bank_mode[i] <= 1'b0;
         end
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else begin
         if (flush) begin
            wr_cnt <= '0;
         end else if (accept) begin
            if (wr_cnt == '0) begin
               bank_len[wr_bank]  <= eff_len;
               bank_mode[wr_bank] <= mode;
            end
            if (wr_last) begin
               bank_st[wr_bank] <= FULL;
               wr_cnt           <= '0;
               wr_bank          <= ~wr_bank;
            end else begin
               wr_cnt <= wr_cnt + ONE;
            end
         end

         // Write and read never target the same bank: one needs EMPTY, the other FULL.
         if (load) begin
            out_data  <= mem[rd_bank][rd_addr[AW-1:0]];
            out_valid <= 1'b1;
            out_last  <= rd_last;
            if (rd_last) begin
               bank_st[rd_bank] <= EMPTY;
               rd_cnt           <= '0;
               rd_bank          <= ~rd_bank;
            end else begin
               rd_cnt <= rd_cnt + ONE;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_frame_reorder.sv
// Self-checking bench for frame_reorder: expected output frames are queued
// when stimulus is driven and compared as the output handshakes complete.
module tb_frame_reorder;

   localparam int BITS  = 8;
   localparam int MAX_N = 16;
   localparam int LW    = $clog2(MAX_N + 1);

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [LW-1:0]   frame_len = '0;
   logic            mode = 1'b0;
   logic            flush = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [BITS-1:0] in_data = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [BITS-1:0] out_data;
   logic            out_last;

   typedef struct packed {
      logic [BITS-1:0] d;
      logic            l;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   n_out = 0;
   int   first_cyc = 0;
   int   last_cyc = 0;
   int   cyc = 0;
   int   ready_drops = 0;

   frame_reorder #(.BITS(BITS), .MAX_N(MAX_N)) dut (
      .clk(clk), .rst_n(rst_n), .frame_len(frame_len), .mode(mode), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // Output scoreboard: a handshake seen at the negedge completes at the next posedge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got data %0d last %0b, required no output", out_data, out_last);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (out_data !== e.d || out_last !== e.l) begin
               errors++;
               $display("FAIL out_sample: got data %0d last %0b, required data %0d last %0b",
                        out_data, out_last, e.d, e.l);
            end
         end
         if (n_out == 0) first_cyc = cyc;
         last_cyc = cyc;
         n_out++;
      end
   end

   task automatic push_frame(input int base, input int len, input bit md);
      for (int i = 0; i < len; i++) begin
         exp_t e;
         e.d = BITS'(md ? base + len - 1 - i : base + i);
         e.l = (i == len - 1);
         sb.push_back(e);
      end
   endtask

   // Called #1 after a posedge; returns #1 after the edge that accepted the sample.
   task automatic put(input logic [BITS-1:0] d, input int fl, input bit md);
      int t;
      t = 0;
      in_valid  = 1'b1;
      in_data   = d;
      frame_len = LW'(fl);
      mode      = md;
      @(negedge clk);
      if (!in_ready) ready_drops++;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL put_timeout: in_ready got 0 after %0d cycles, required 1", t);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input int base, input int len, input int fl, input bit md);
      for (int i = 0; i < len; i++) put(BITS'(base + i), fl, md);
   endtask

   task automatic wait_drain(input int budget);
      int t;
      t = 0;
      while (sb.size() != 0 && t < budget) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d samples outstanding, required 0", sb.size());
         sb.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got valid %0b data %0d last %0b, required 0 0 0", out_valid, out_data, out_last);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid: got %0b, required 0", out_valid);
      end
   endtask

   task automatic test_reversed();
      out_ready = 1'b1;
      push_frame(0, 10, 1'b1);
      send_frame(0, 10, 10, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_early: out_valid got %0b, required 0", out_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'd9) begin
         errors++;
         $display("FAIL latency_first: got valid %0b data %0d, required valid 1 data 9", out_valid, out_data);
      end
      wait_drain(50);
   endtask

   task automatic test_back_to_back();
      out_ready   = 1'b1;
      n_out       = 0;
      ready_drops = 0;
      for (int f = 0; f < 5; f++) push_frame(f * 8, 8, (f % 2) == 0);
      for (int f = 0; f < 5; f++) send_frame(f * 8, 8, 8, (f % 2) == 0);
      wait_drain(50);
      checks++;
      if (ready_drops != 0) begin
         errors++;
         $display("FAIL stream_in_ready: got %0d stalls, required 0", ready_drops);
      end
      checks++;
      if (n_out != 40 || last_cyc - first_cyc != 39) begin
         errors++;
         $display("FAIL stream_gapless: got %0d outputs over %0d cycles, required 40 over 40",
                  n_out, last_cyc - first_cyc + 1);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      push_frame(60, 4, 1'b0);
      push_frame(64, 4, 1'b1);
      send_frame(60, 4, 4, 1'b0);
      send_frame(64, 4, 4, 1'b1);
      in_valid  = 1'b1;
      in_data   = 8'd68;
      frame_len = LW'(4);
      mode      = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready: got %0b, required 0", in_ready);
         end
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'd60 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: got valid %0b data %0d last %0b, required 1 60 0", out_valid, out_data, out_last);
         end
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== (k == 3)) begin
            errors++;
            $display("FAIL bp_release_ready: cycle %0d got %0b, required %0b", k, in_ready, k == 3);
         end
      end
      @(posedge clk);
      #1;
      push_frame(68, 4, 1'b0);
      send_frame(68, 4, 4, 1'b0);
      wait_drain(50);
   endtask

   task automatic test_len_clamp();
      out_ready = 1'b1;
      push_frame(100, 16, 1'b1);
      push_frame(200, 16, 1'b1);
      send_frame(100, 16, 0, 1'b1);
      send_frame(200, 16, 20, 1'b1);
      wait_drain(80);
   endtask

   task automatic test_flush();
      int n_before;
      out_ready = 1'b1;
      send_frame(16, 5, 10, 1'b1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      push_frame(8'hA0, 10, 1'b1);
      send_frame(8'hA0, 10, 10, 1'b1);
      wait_drain(50);
      n_before = n_out;
      send_frame(32, 9, 10, 1'b1);
      in_valid = 1'b1;
      in_data  = 8'd41;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (n_out != n_before || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_last: got %0d outputs valid %0b, required 0 outputs valid 0", n_out - n_before, out_valid);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_in_ready: got %0b, required 1", in_ready);
      end
      push_frame(64, 3, 1'b0);
      send_frame(64, 3, 3, 1'b0);
      wait_drain(30);
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      push_frame(50, 6, 1'b1);
      send_frame(50, 6, 6, 1'b1);
      send_frame(8'h77, 3, 6, 1'b1);
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got valid %0b data %0d last %0b, required 0 0 0", out_valid, out_data, out_last);
      end
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_in_ready: got %0b, required 1", in_ready);
      end
      push_frame(8'h30, 4, 1'b1);
      send_frame(8'h30, 4, 4, 1'b1);
      wait_drain(30);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      test_reset();
      test_reversed();
      test_back_to_back();
      test_backpressure();
      test_len_clamp();
      test_flush();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_reorder.md
Name: frame_reorder

Overview:
- Ping-pong frame buffer that re-emits each input frame either reversed (last sample first) or in original order.
- Frame length and mode are selectable at runtime, per frame; each input frame is a run of frame_len accepted samples.
- Valid/ready handshakes on both sides give full backpressure; sustains 1 sample/cycle.
- Sits between sample-stream producers and FFT/filter stages that need time-reversed or re-framed data.

Parameters:
BITS, 8, sample width
MAX_N, 16, maximum frame length (>=2); each of the two banks holds MAX_N samples
LW, $clog2(MAX_N+1), width of frame_len (derived, do not override)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
frame_len  in  LW  samples per frame; sampled with first sample of each frame
mode  in  1  0 = in-order, 1 = reversed; sampled with first sample of each frame
flush  in  1  synchronous abort of the partially written frame
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
in_data  in  BITS  input sample
out_valid  out  1  out_data/out_last valid
out_ready  in  1  downstream accepts output this cycle
out_data  out  BITS  output sample
out_last  out  1  marks final sample of an output frame

Behaviour:
- Reset (async, rst_n low): banks EMPTY, wr_bank=rd_bank=0, wr_cnt=rd_cnt=0, out_valid=0, out_data=0, out_last=0. Memory contents not reset. Reset mid-frame discards all buffered and in-flight data; in_ready=1 in the first cycle after release.
- Effective length L: frame_len if 1..MAX_N; frame_len=0 or >MAX_N is clamped to MAX_N.
- Bank state per bank: EMPTY or FULL, plus latched L and mode. A bank is written only while EMPTY and read only while FULL.
- in_ready = bank[wr_bank] is EMPTY. This is combinational from registers only, with no path from in_valid or out_ready.
- Input accept = in_valid & in_ready:
  - Sample goes to mem[wr_bank][wr_cnt].
  - If wr_cnt==0, L and mode are latched for that bank.
  - If wr_cnt==L-1: bank goes FULL, wr_cnt<=0, wr_bank toggles.
  - Otherwise wr_cnt increments.
  - frame_len/mode changes mid-frame are ignored.
- flush: wr_cnt<=0 and the partial frame is dropped. FULL banks and the read side are unaffected.
  - flush with an accept in the same cycle: the flush wins and the sample is dropped.
  - If the accept would have completed the frame, the bank stays EMPTY.
- Output register load condition: bank[rd_bank] FULL and (!out_valid | out_ready).
  - out_data <= mem[rd_bank][a], where a = rd_cnt (mode 0) or L-1-rd_cnt (mode 1).
  - out_valid<=1; out_last <= (rd_cnt==L-1).
  - On the last element: bank goes EMPTY, rd_cnt<=0, rd_bank toggles. Otherwise rd_cnt increments.
  - A bank freed by a load is writable in the next cycle.
- If out_valid & out_ready and there is no load: out_valid<=0 and out_last<=0. out_data holds its value.
- Stall: while out_valid & !out_ready, out_data and out_last are held stable.
- Latency: first output sample is valid the cycle after the frame's last input sample is accepted, i.e. one register stage after bank FULL.
- Throughput: with in_valid=1 and out_ready=1 continuously, in_ready stays 1 and output is gap-free after the first frame (one bank fills while the other drains).
- Simultaneous events:
  - One bank completing a write while the other bank is freed by a read: both happen, with no conflict.
  - Both banks FULL: in_ready=0 until a bank is freed.
- L=1: every accepted sample is its own frame and out_last=1 on each output.

Test Plan:
1. MAX_N=16, frame_len=10, mode=1, inputs 0..9, out_ready=1 -> outputs 9,8,...,0 starting the cycle after input 9 is accepted; out_last only on 0.
2. Continuous stream 0..39, frame_len=8, mode alternating per frame 1,0,1,0,1 -> 7..0, 8..15, 23..16, 24..31, 39..32 with no output gaps after the first frame; in_ready never drops.
3. out_ready=0 while writing 3 frames of length 4 -> in_ready falls after the 8th sample; 9th sample not accepted. out_data/out_last hold under stall. Release out_ready -> first frame drains, in_ready=1 the cycle after bank freed.
4. frame_len=0 and frame_len=20, mode=1 -> treated as 16; 16-sample reversed frames.
5. flush after 5 of 10 samples, then a fresh 10-sample frame a0..a9, mode=1 -> only a9..a0 emitted. flush coincident with the 10th accept -> nothing emitted.
6. Assert rst_n low mid-drain -> out_valid=0, out_data=0 immediately. After release, in_ready=1 and a new frame reverses correctly with no stale samples.
